// File: rtl/pc_ctrl.sv
// Next-PC sequencer and stall controller for the pc register.
// Tracks the mult/div busy window and holds redirects that land in a stall.
module pc_ctrl #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter logic [31:0] EXC_VECTOR  = 32'h0000_4180,
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] curr_pc,
   input  logic        br_req,
   input  logic [31:0] br_target,
   input  logic        hazard_stall,
   input  logic        md_start,
   input  logic        md_is_div,
   input  logic        md_use,
   input  logic        exc_req,
   input  logic        eret_req,
   input  logic [31:0] epc,
   output logic [31:0] next_pc,
   output logic        pc_enable,
   output logic        fetch_flush,
   output logic        md_busy
);

   logic [4:0]  md_cnt;
   logic        pend_valid;
   logic [31:0] pend_target;
   logic        pend_valid_d;
   logic [31:0] pend_target_d;
   logic        stall;
   logic        md_accept;

   assign md_busy = (md_cnt != 5'd0);
   assign stall   = hazard_stall | (md_busy & (md_use | md_start));

   assign md_accept = md_start & ~md_busy & ~stall
                    & ~exc_req & ~eret_req & ~reset;

   // Counter runs down unconditionally once loaded, so busy lasts N cycles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         md_cnt <= 5'd0;
      end else if (md_accept) begin
         md_cnt <= md_is_div ? 5'(DIV_CYCLES) : 5'(MULT_CYCLES);
      end else if (md_cnt != 5'd0) begin
         md_cnt <= md_cnt - 5'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_valid  <= 1'b0;
         pend_target <= 32'd0;
      end else begin
         pend_valid  <= pend_valid_d;
         pend_target <= pend_target_d;
      end
   end

   always_comb begin
      next_pc       = curr_pc + 32'd4;
      pc_enable     = 1'b1;
      fetch_flush   = 1'b0;
      pend_valid_d  = pend_valid;
      pend_target_d = pend_target;
      if (reset) begin
         next_pc      = RESET_PC;
         pend_valid_d = 1'b0;
      end else if (exc_req) begin
         next_pc      = EXC_VECTOR;
         fetch_flush  = 1'b1;
         pend_valid_d = 1'b0;
      end else if (eret_req) begin
         next_pc      = epc;
         fetch_flush  = 1'b1;
         pend_valid_d = 1'b0;
      end else if (stall) begin
         next_pc   = curr_pc;
         pc_enable = 1'b0;
         if (br_req) begin
            pend_valid_d  = 1'b1;
            pend_target_d = br_target;
         end
      end else if (br_req) begin
         next_pc      = br_target;
         fetch_flush  = 1'b1;
         pend_valid_d = 1'b0;
      end else if (pend_valid) begin
         next_pc      = pend_target;
         fetch_flush  = 1'b1;
         pend_valid_d = 1'b0;
      end
   end

endmodule

// File: tb/tb_pc_ctrl.sv
// Scoreboard bench for pc_ctrl: expected outputs are queued with each
// stimulus step and popped when the combinational outputs are sampled.
module tb_pc_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] curr_pc = '0;
   logic        br_req = 1'b0;
   logic [31:0] br_target = '0;
   logic        hazard_stall = 1'b0;
   logic        md_start = 1'b0;
   logic        md_is_div = 1'b0;
   logic        md_use = 1'b0;
   logic        exc_req = 1'b0;
   logic        eret_req = 1'b0;
   logic [31:0] epc = '0;
   logic [31:0] next_pc;
   logic        pc_enable;
   logic        fetch_flush;
   logic        md_busy;

   localparam logic [6:0] NONE = 7'b0000000;
   localparam logic [6:0] HZ   = 7'b1000000;
   localparam logic [6:0] BR   = 7'b0100000;
   localparam logic [6:0] MS   = 7'b0010000;
   localparam logic [6:0] DV   = 7'b0001000;
   localparam logic [6:0] US   = 7'b0000100;
   localparam logic [6:0] EX   = 7'b0000010;
   localparam logic [6:0] ER   = 7'b0000001;

   // {next_pc, pc_enable, fetch_flush, md_busy}
   typedef logic [34:0] exp_t;

   exp_t sb[$];
   int   n_run  = 0;
   int   n_fail = 0;

   pc_ctrl dut (
      .clk(clk), .reset(reset), .curr_pc(curr_pc),
      .br_req(br_req), .br_target(br_target),
      .hazard_stall(hazard_stall), .md_start(md_start),
      .md_is_div(md_is_div), .md_use(md_use),
      .exc_req(exc_req), .eret_req(eret_req), .epc(epc),
      .next_pc(next_pc), .pc_enable(pc_enable),
      .fetch_flush(fetch_flush), .md_busy(md_busy)
   );

   always #5 clk = ~clk;

   function automatic exp_t ex(input logic [31:0] pc, input logic en,
                               input logic fl, input logic bsy);
      return {pc, en, fl, bsy};
   endfunction

   // Drive one cycle of inputs at the falling edge and queue its expectation.
   task automatic apply(input logic [6:0] ctl, input logic [31:0] cpc,
                        input logic [31:0] tgt, input exp_t e);
      @(negedge clk);
      {hazard_stall, br_req, md_start, md_is_div, md_use, exc_req, eret_req} = ctl;
      curr_pc   = cpc;
      br_target = tgt;
      sb.push_back(e);
      #2;
   endtask

   task automatic test_reset;
      logic [6:0]  c [2] = '{BR | EX, NONE};
      logic [31:0] p [2] = '{32'h1234, 32'h88};
      exp_t        e [2];
      exp_t        got, want;
      e[0] = ex(32'h0, 1'b1, 1'b0, 1'b0);
      e[1] = ex(32'h0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         apply(c[i], p[i], 32'h999, e[i]);
         got  = {next_pc, pc_enable, fetch_flush, md_busy};
         want = sb.pop_front();
         n_run++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL reset[%0d] got pc=%h en/fl/busy=%b want pc=%h en/fl/busy=%b",
                     i, got[34:3], got[2:0], want[34:3], want[2:0]);
         end
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_seq;
      exp_t got, want;
      for (int i = 0; i < 3; i++) begin
         apply(NONE, 32'(i * 4), 32'h0, ex(32'(i * 4 + 4), 1'b1, 1'b0, 1'b0));
         got  = {next_pc, pc_enable, fetch_flush, md_busy};
         want = sb.pop_front();
         n_run++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL seq[%0d] got pc=%h en/fl/busy=%b want pc=%h en/fl/busy=%b",
                     i, got[34:3], got[2:0], want[34:3], want[2:0]);
         end
      end
   endtask

   task automatic test_redirect_stall;
      logic [6:0]  c [10] = '{HZ | BR, HZ, NONE, NONE,
                              HZ | BR, HZ | BR, NONE,
                              HZ | BR, BR, NONE};
      logic [31:0] p [10] = '{32'h10, 32'h10, 32'h10, 32'h100,
                              32'h10, 32'h10, 32'h10,
                              32'h20, 32'h20, 32'h500};
      logic [31:0] t [10] = '{32'h100, 32'h0, 32'h0, 32'h0,
                              32'h200, 32'h300, 32'h0,
                              32'h400, 32'h500, 32'h0};
      exp_t        e [10];
      exp_t        got, want;
      e[0] = ex(32'h10,  1'b0, 1'b0, 1'b0);
      e[1] = ex(32'h10,  1'b0, 1'b0, 1'b0);
      e[2] = ex(32'h100, 1'b1, 1'b1, 1'b0);
      e[3] = ex(32'h104, 1'b1, 1'b0, 1'b0);
      e[4] = ex(32'h10,  1'b0, 1'b0, 1'b0);
      e[5] = ex(32'h10,  1'b0, 1'b0, 1'b0);
      e[6] = ex(32'h300, 1'b1, 1'b1, 1'b0);
      e[7] = ex(32'h20,  1'b0, 1'b0, 1'b0);
      e[8] = ex(32'h500, 1'b1, 1'b1, 1'b0);
      e[9] = ex(32'h504, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         apply(c[i], p[i], t[i], e[i]);
         got  = {next_pc, pc_enable, fetch_flush, md_busy};
         want = sb.pop_front();
         n_run++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL redirect[%0d] got pc=%h en/fl/busy=%b want pc=%h en/fl/busy=%b",
                     i, got[34:3], got[2:0], want[34:3], want[2:0]);
         end
      end
   endtask

   task automatic test_divide;
      exp_t got, want;
      logic stl, bsy;
      for (int k = 0; k < 12; k++) begin
         stl = (k >= 3) && (k <= 10);
         bsy = (k >= 1) && (k <= 10);
         apply(k == 0 ? (MS | DV) : (k >= 3 ? US : NONE), 32'h20, 32'h0,
               ex(stl ? 32'h20 : 32'h24, ~stl, 1'b0, bsy));
         got  = {next_pc, pc_enable, fetch_flush, md_busy};
         want = sb.pop_front();
         n_run++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL divide[%0d] got pc=%h en/fl/busy=%b want pc=%h en/fl/busy=%b",
                     k, got[34:3], got[2:0], want[34:3], want[2:0]);
         end
      end
   endtask

   task automatic test_back_to_back;
      exp_t got, want;
      logic stl, bsy;
      for (int k = 0; k < 13; k++) begin
         stl = (k >= 2) && (k <= 5);
         bsy = ((k >= 1) && (k <= 5)) || ((k >= 7) && (k <= 11));
         apply((k == 0 || (k >= 2 && k <= 6)) ? MS : NONE, 32'h30, 32'h0,
               ex(stl ? 32'h30 : 32'h34, ~stl, 1'b0, bsy));
         got  = {next_pc, pc_enable, fetch_flush, md_busy};
         want = sb.pop_front();
         n_run++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL mult_b2b[%0d] got pc=%h en/fl/busy=%b want pc=%h en/fl/busy=%b",
                     k, got[34:3], got[2:0], want[34:3], want[2:0]);
         end
      end
   endtask

   task automatic test_priority;
      logic [6:0]  c [5] = '{HZ | BR | EX | ER, NONE, HZ | BR | ER, NONE, NONE};
      logic [31:0] p [5] = '{32'h10, 32'h4180, 32'h4184, 32'h800, 32'hFFFF_FFFC};
      exp_t        e [5];
      exp_t        got, want;
      e[0] = ex(32'h4180, 1'b1, 1'b1, 1'b0);
      e[1] = ex(32'h4184, 1'b1, 1'b0, 1'b0);
      e[2] = ex(32'h800,  1'b1, 1'b1, 1'b0);
      e[3] = ex(32'h804,  1'b1, 1'b0, 1'b0);
      e[4] = ex(32'h0,    1'b1, 1'b0, 1'b0);
      epc = 32'h800;
      for (int i = 0; i < 5; i++) begin
         apply(c[i], p[i], 32'h900, e[i]);
         got  = {next_pc, pc_enable, fetch_flush, md_busy};
         want = sb.pop_front();
         n_run++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL prio_wrap[%0d] got pc=%h en/fl/busy=%b want pc=%h en/fl/busy=%b",
                     i, got[34:3], got[2:0], want[34:3], want[2:0]);
         end
      end
   endtask

   task automatic test_async_reset;
      logic [6:0]  c [3] = '{MS, HZ | BR, HZ};
      logic [31:0] p [3] = '{32'h50, 32'h54, 32'h54};
      exp_t        e [5];
      exp_t        got, want;
      e[0] = ex(32'h54, 1'b1, 1'b0, 1'b0);
      e[1] = ex(32'h54, 1'b0, 1'b0, 1'b1);
      e[2] = ex(32'h54, 1'b0, 1'b0, 1'b1);
      e[3] = ex(32'h0,  1'b1, 1'b0, 1'b0);
      e[4] = ex(32'h64, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         if (i < 3) begin
            apply(c[i], p[i], 32'h700, e[i]);
         end else if (i == 3) begin
            @(negedge clk);
            {hazard_stall, br_req, md_start, md_is_div, md_use, exc_req, eret_req} = NONE;
            curr_pc = 32'h54;
            #1 reset = 1'b1;
            sb.push_back(e[i]);
            #1;
         end else begin
            @(negedge clk);
            reset = 1'b0;
            apply(NONE, 32'h60, 32'h0, e[i]);
         end
         got  = {next_pc, pc_enable, fetch_flush, md_busy};
         want = sb.pop_front();
         n_run++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL async_rst[%0d] got pc=%h en/fl/busy=%b want pc=%h en/fl/busy=%b",
                     i, got[34:3], got[2:0], want[34:3], want[2:0]);
         end
      end
   endtask

   initial begin
      test_reset;
      test_seq;
      test_redirect_stall;
      test_divide;
      test_back_to_back;
      test_priority;
      test_async_reset;
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
